store_buffer: RTL and testbench

Posted-store buffer between the MEM-stage pipeline register and the `lsu`. Stores retire from the pipeline into a small FIFO in one cycle and drain to the `lsu` on cycles when the `lsu` port carries no load. Loads get the port first. Loads that overlap a buffered store, loads from I/O space, and fences stall the pipeline until the hazard has drained. An optional path forwards a single fully-covering buffered store to a load.

---
 rtl/store_buffer.sv | 126 ++++++++++++
 tb/tb_store_buffer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer: posted-store FIFO between the MEM stage and the lsu; loads take the lsu port first
// Ports: i_clk, i_reset (synchronous, active-low)
//        i_req_valid/wren/addr/wdata/funct3, i_fence : MEM-stage request
//        o_stall, o_ld_data                           : back to the pipeline (combinational)
//        o_lsu_addr/st_data/wren/funct3, i_lsu_ld_data: lsu port
//        o_sb_count, o_sb_empty                       : occupancy
// Define SB_FWD_EN to forward a single fully covering buffered store to a load without stalling.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_req_valid,
  input  logic                     i_req_wren,
  input  logic [31:0]              i_req_addr,
  input  logic [31:0]              i_req_wdata,
  input  logic [2:0]               i_req_funct3,
  input  logic                     i_fence,
  output logic                     o_stall,
  output logic [31:0]              o_ld_data,
  output logic [31:0]              o_lsu_addr,
  output logic [31:0]              o_lsu_st_data,
  output logic                     o_lsu_wren,
  output logic [2:0]               o_lsu_funct3,
  input  logic [31:0]              i_lsu_ld_data,
  output logic [$clog2(DEPTH):0]   o_sb_count,
  output logic                     o_sb_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [31:0] e_addr [DEPTH];
  logic [31:0] e_data [DEPTH];
  logic [2:0] e_f3 [DEPTH];
  logic [3:0] e_mask [DEPTH];
  logic [AW-1:0] head, tail;
  logic [CW-1:0] count;
  logic ld, ld_ram, nonempty, haz, fwd, fence_stall, port_load, drain, push;
  logic [7:0] fp;
  logic [13:0] ld_w;
  logic [DEPTH-1:0] ovl;

  function automatic logic [3:0] st_mask(input logic [2:0] f3, input logic [1:0] a);
    return f3[1] ? 4'hf : f3[0] ? (a[1] ? 4'hc : 4'h3) : 4'h1 << a;
  endfunction

  assign ld = i_req_valid & ~i_req_wren;
  assign ld_ram = i_req_addr[31:16] == 16'h0;
  assign nonempty = count != '0;
  assign ld_w = i_req_addr[15:2];
  // low nibble covers word W, high nibble the spill into W+1
  assign fp = (i_req_funct3[1] ? 8'h0f : i_req_funct3[0] ? 8'h03 : 8'h01) << i_req_addr[1:0];

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [AW-1:0] rel;
    logic [13:0] w;
    assign rel = AW'(i) - head;
    assign w = e_addr[i][15:2];
    assign ovl[i] = ({1'b0, rel} < count) && e_addr[i][31:16] == 16'h0 &&
                    ((w == ld_w && |(e_mask[i] & fp[3:0])) ||
                     (w == ld_w + 14'd1 && |(e_mask[i] & fp[7:4])));
  end

`ifdef SB_FWD_EN
  logic [31:0] sel_data, aligned, shd, fwd_data;
  logic [3:0] sel_mask;
  logic [1:0] sel_sh;
  always_comb begin
    sel_data = '0;
    sel_mask = '0;
    sel_sh = '0;
    for (int i = 0; i < DEPTH; i++)
      if (ovl[i]) begin
        sel_data = e_data[i];
        sel_mask = e_mask[i];
        sel_sh = e_f3[i][1] ? 2'd0 : e_f3[i][0] ? {e_addr[i][1], 1'b0} : e_addr[i][1:0];
      end
  end
  // place the store data in its memory byte lanes, then extract like the lsu does
  assign aligned = sel_data << {sel_sh, 3'b0};
  assign shd = aligned >> {i_req_addr[1:0], 3'b0};
  assign fwd_data = i_req_funct3[1] ? shd :
                    i_req_funct3[0] ? {{16{~i_req_funct3[2] & shd[15]}}, shd[15:0]} :
                                      {{24{~i_req_funct3[2] & shd[7]}}, shd[7:0]};
  assign fwd = ld & ld_ram & ~|fp[7:4] & $onehot(ovl) & ((sel_mask & fp[3:0]) == fp[3:0]);
  assign o_ld_data = fwd ? fwd_data : i_lsu_ld_data;
`else
  assign fwd = 1'b0;
  assign o_ld_data = i_lsu_ld_data;
`endif

  // I/O loads wait for the whole buffer to keep I/O accesses in order
  assign haz = ld & (ld_ram ? |ovl : nonempty);
  assign fence_stall = i_fence & nonempty;
  assign o_stall = (haz & ~fwd) | fence_stall;
  assign port_load = ld & ~haz & ~fence_stall;
  assign drain = nonempty & ~port_load;
  assign push = i_req_valid & i_req_wren & ~o_stall;

  assign o_lsu_wren = drain;
  assign o_lsu_addr = drain ? e_addr[head] : i_req_addr;
  assign o_lsu_st_data = drain ? e_data[head] : i_req_wdata;
  assign o_lsu_funct3 = drain ? e_f3[head] : i_req_funct3;
  assign o_sb_count = count;
  assign o_sb_empty = ~nonempty;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (drain) head <= head + 1'b1;
      count <= count + CW'(push) - CW'(drain);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset && push) begin
      e_addr[tail] <= i_req_addr;
      e_data[tail] <= i_req_wdata;
      e_f3[tail] <= i_req_funct3;
      e_mask[tail] <= st_mask(i_req_funct3, i_req_addr[1:0]);
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed and randomized checks of store_buffer against a program-order memory model
module tb_store_buffer;
  localparam int DEPTH = 4;
`ifdef SB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic i_clk = 1'b0, i_reset = 1'b0, i_req_valid = 1'b0, i_req_wren = 1'b0, i_fence = 1'b0;
  logic [31:0] i_req_addr = '0, i_req_wdata = '0;
  logic [2:0] i_req_funct3 = '0;
  logic o_stall, o_lsu_wren, o_sb_empty;
  logic [31:0] o_ld_data, o_lsu_addr, o_lsu_st_data, i_lsu_ld_data, lsu_word;
  logic [2:0] o_lsu_funct3;
  logic [$clog2(DEPTH):0] o_sb_count;
  int checks = 0, failures = 0;
  logic [7:0] mem [65536];
  logic [7:0] ref_mem [65536];
  logic mem_init = 1'b0;
  logic [31:0] io_last = '0;
  int io_writes = 0;
  typedef struct {logic [31:0] addr; logic [31:0] data; logic [2:0] f3;} st_t;
  st_t q[$];

  store_buffer #(.DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_req_valid(i_req_valid), .i_req_wren(i_req_wren),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .i_req_funct3(i_req_funct3),
    .i_fence(i_fence), .o_stall(o_stall), .o_ld_data(o_ld_data), .o_lsu_addr(o_lsu_addr),
    .o_lsu_st_data(o_lsu_st_data), .o_lsu_wren(o_lsu_wren), .o_lsu_funct3(o_lsu_funct3),
    .i_lsu_ld_data(i_lsu_ld_data), .o_sb_count(o_sb_count), .o_sb_empty(o_sb_empty)
  );

  always #5 i_clk = ~i_clk;

  function automatic int sz(input logic [2:0] f);
    return 1 << f[1:0];
  endfunction
  // first byte in the word a store of this size/address writes
  function automatic int store_lo(input logic [31:0] a, input logic [2:0] f);
    return f[1] ? 0 : f[0] ? (a[1] ? 2 : 0) : int'(a[1:0]);
  endfunction
  function automatic logic is_ram(input logic [31:0] a);
    return a[31:16] == 16'h0;
  endfunction
  function automatic logic [31:0] io_rd(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction
  function automatic logic [31:0] ext(input logic [31:0] w, input logic [1:0] off, input logic [2:0] f);
    logic [31:0] s;
    s = w >> (8 * off);
    case (f)
      3'd0: return {{24{s[7]}}, s[7:0]};
      3'd1: return {{16{s[15]}}, s[15:0]};
      3'd4: return {24'h0, s[7:0]};
      3'd5: return {16'h0, s[15:0]};
      default: return s;
    endcase
  endfunction
  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f);
    logic [31:0] w;
    w = is_ram(a) ? {ref_mem[{a[15:2], 2'd3}], ref_mem[{a[15:2], 2'd2}], ref_mem[{a[15:2], 2'd1}], ref_mem[{a[15:2], 2'd0}]} : io_rd(a);
    return ext(w, a[1:0], f);
  endfunction
  task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    int lo;
    lo = store_lo(a, f);
    if (is_ram(a))
      for (int b = lo; b < lo + sz(f); b++) ref_mem[{a[15:2], 2'(b)}] = d[8*(b-lo) +: 8];
  endtask
  task automatic resync();
    for (int i = 0; i < 65536; i++) ref_mem[i] = mem[i];
  endtask

  // behavioural lsu: byte-addressed RAM below 64K, I/O writes logged
  always @(posedge i_clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 65536; i++) mem[i] <= 8'(i * 37 + 5);
      mem_init <= 1'b1;
    end else if (i_reset && o_lsu_wren) begin
      if (is_ram(o_lsu_addr)) begin
        for (int b = 0; b < 4; b++)
          if (b >= store_lo(o_lsu_addr, o_lsu_funct3) && b < store_lo(o_lsu_addr, o_lsu_funct3) + sz(o_lsu_funct3))
            mem[{o_lsu_addr[15:2], 2'(b)}] <= o_lsu_st_data[8*(b-store_lo(o_lsu_addr, o_lsu_funct3)) +: 8];
      end else begin
        io_last <= o_lsu_addr;
        io_writes <= io_writes + 1;
      end
    end
  end
  always_comb begin
    lsu_word = is_ram(o_lsu_addr) ? {mem[{o_lsu_addr[15:2], 2'd3}], mem[{o_lsu_addr[15:2], 2'd2}],
                                     mem[{o_lsu_addr[15:2], 2'd1}], mem[{o_lsu_addr[15:2], 2'd0}]} : io_rd(o_lsu_addr);
    i_lsu_ld_data = ext(lsu_word, o_lsu_addr[1:0], o_lsu_funct3);
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f, input logic fn);
    i_req_valid = v;
    i_req_wren = w;
    i_req_addr = a;
    i_req_wdata = d;
    i_req_funct3 = f;
    i_fence = fn;
  endtask
  // issue one request (or a bare fence) and hold it until accepted; reports stall cycles
  task automatic op(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f, input logic fn,
                    output int st, output logic [31:0] ld, output int iw);
    drive(~fn, w, a, d, f, fn);
    st = 0;
    ld = '0;
    iw = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge i_clk);
      if (!o_stall) begin
        ld = o_ld_data;
        iw = io_writes;
        break;
      end
      st++;
      step();
    end
    step();
    if (!fn && w) ref_store(a, d, f);
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic test_reset();
    int st, iw;
    logic [31:0] ld;
    logic [31:0] saved;
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
    i_reset = 1'b0;
    step();
    step();
    i_reset = 1'b1;
    resync();
    @(negedge i_clk);
    checks++; if (o_sb_count !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", o_sb_count); end
    checks++; if (o_sb_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", o_sb_empty); end
    checks++; if (o_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", o_stall); end
    checks++; if (o_lsu_wren !== 1'b0) begin failures++; $display("FAIL reset_wren got=%b exp=0", o_lsu_wren); end
    checks++; if (o_ld_data !== i_lsu_ld_data) begin failures++; $display("FAIL reset_ld got=%h exp=%h", o_ld_data, i_lsu_ld_data); end
    step();
    saved = {mem[16'h143], mem[16'h142], mem[16'h141], mem[16'h140]};
    op(1'b1, 32'h140, 32'h1234_5678, 3'd2, 1'b0, st, ld, iw);
    i_reset = 1'b0;
    @(negedge i_clk);
    checks++; if (o_sb_count !== 1) begin failures++; $display("FAIL prereset_count got=%0d exp=1", o_sb_count); end
    step();
    i_reset = 1'b1;
    @(negedge i_clk);
    checks++; if (o_sb_count !== '0) begin failures++; $display("FAIL midreset_count got=%0d exp=0", o_sb_count); end
    checks++; if (o_sb_empty !== 1'b1) begin failures++; $display("FAIL midreset_empty got=%b exp=1", o_sb_empty); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (o_lsu_wren !== 1'b0) begin failures++; $display("FAIL postreset_wren cyc=%0d got=%b exp=0", k, o_lsu_wren); end
      step();
      @(negedge i_clk);
    end
    checks++;
    if ({mem[16'h143], mem[16'h142], mem[16'h141], mem[16'h140]} !== saved) begin
      failures++; $display("FAIL reset_discard got=%h exp=%h", {mem[16'h143], mem[16'h142], mem[16'h141], mem[16'h140]}, saved);
    end
    step();
    resync();
  endtask

  task automatic test_sw_lw();
    int st, iw;
    logic [31:0] ld;
    op(1'b1, 32'h100, 32'hDEAD_BEEF, 3'd2, 1'b0, st, ld, iw);
    checks++; if (st !== 0) begin failures++; $display("FAIL sw_stall got=%0d exp=0", st); end
    op(1'b0, 32'h100, '0, 3'd2, 1'b0, st, ld, iw);
    checks++; if (st !== (FWD ? 0 : 1)) begin failures++; $display("FAIL lw_stalls got=%0d exp=%0d", st, FWD ? 0 : 1); end
    checks++; if (ld !== 32'hDEAD_BEEF) begin failures++; $display("FAIL lw_data got=%h exp=deadbeef", ld); end
    step();
  endtask

  task automatic test_partial();
    int st, iw;
    logic [31:0] ld, exp;
    op(1'b1, 32'h101, 32'h0000_0080, 3'd0, 1'b0, st, ld, iw);
    exp = {16'hFFFF, 8'h80, ref_mem[16'h0100]};
    op(1'b0, 32'h100, '0, 3'd1, 1'b0, st, ld, iw);
    checks++; if (st !== 1) begin failures++; $display("FAIL partial_stalls got=%0d exp=1", st); end
    checks++; if (ld !== exp) begin failures++; $display("FAIL partial_data got=%h exp=%h", ld, exp); end
    step();
  endtask

  task automatic test_forward();
    int st, iw;
    logic [31:0] ld, exp;
    op(1'b1, 32'h102, 32'h1234_8765, 3'd1, 1'b0, st, ld, iw);
    op(1'b0, 32'h102, '0, 3'd5, 1'b0, st, ld, iw);
    checks++; if (st !== (FWD ? 0 : 1)) begin failures++; $display("FAIL fwd_stalls got=%0d exp=%0d", st, FWD ? 0 : 1); end
    checks++; if (ld !== 32'h0000_8765) begin failures++; $display("FAIL fwd_data got=%h exp=00008765", ld); end
    op(1'b1, 32'h108, 32'h0000_005A, 3'd0, 1'b0, st, ld, iw);
    exp = ref_load(32'h104, 3'd2);
    op(1'b0, 32'h104, '0, 3'd2, 1'b0, st, ld, iw);
    checks++; if (st !== 0) begin failures++; $display("FAIL miss_stalls got=%0d exp=0", st); end
    checks++; if (ld !== exp) begin failures++; $display("FAIL miss_data got=%h exp=%h", ld, exp); end
    exp = ref_load(32'h10B, 3'd0);
    op(1'b0, 32'h10B, '0, 3'd0, 1'b0, st, ld, iw);
    checks++; if (st !== 0) begin failures++; $display("FAIL samewd_stalls got=%0d exp=0", st); end
    checks++; if (ld !== exp) begin failures++; $display("FAIL samewd_data got=%h exp=%h", ld, exp); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] drained[$];
    for (int k = 0; k < DEPTH + 2; k++) begin
      drive(1'b1, 1'b1, 32'h200 + 32'(4 * k), 32'hA000 + 32'(k), 3'd2, 1'b0);
      @(negedge i_clk);
      checks++; if (o_stall !== 1'b0) begin failures++; $display("FAIL b2b_stall k=%0d got=%b exp=0", k, o_stall); end
      checks++; if (o_sb_count !== (k == 0 ? 0 : 1)) begin failures++; $display("FAIL b2b_count k=%0d got=%0d exp=%0d", k, o_sb_count, k == 0 ? 0 : 1); end
      if (o_lsu_wren) drained.push_back(o_lsu_addr);
      step();
      ref_store(32'h200 + 32'(4 * k), 32'hA000 + 32'(k), 3'd2);
    end
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      if (o_lsu_wren) drained.push_back(o_lsu_addr);
      step();
    end
    checks++; if (drained.size() !== DEPTH + 2) begin failures++; $display("FAIL b2b_drains got=%0d exp=%0d", drained.size(), DEPTH + 2); end
    for (int k = 0; k < drained.size(); k++) begin
      checks++; if (drained[k] !== 32'h200 + 32'(4 * k)) begin failures++; $display("FAIL b2b_order k=%0d got=%h exp=%h", k, drained[k], 32'h200 + 32'(4 * k)); end
    end
    @(negedge i_clk);
    checks++; if (o_sb_empty !== 1'b1) begin failures++; $display("FAIL b2b_empty got=%b exp=1", o_sb_empty); end
    step();
  endtask

  task automatic test_io();
    int st, iw, w0;
    logic [31:0] ld;
    op(1'b1, 32'h1000_0000, 32'h55, 3'd2, 1'b0, st, ld, iw);
    w0 = io_writes;
    op(1'b0, 32'h1001_0000, '0, 3'd2, 1'b0, st, ld, iw);
    checks++; if (st !== 1) begin failures++; $display("FAIL io_stalls got=%0d exp=1", st); end
    checks++; if (iw !== w0 + 1) begin failures++; $display("FAIL io_order got=%0d exp=%0d", iw, w0 + 1); end
    checks++; if (io_last !== 32'h1000_0000) begin failures++; $display("FAIL io_addr got=%h exp=10000000", io_last); end
    checks++; if (ld !== io_rd(32'h1001_0000)) begin failures++; $display("FAIL io_data got=%h exp=%h", ld, io_rd(32'h1001_0000)); end
    step();
  endtask

  task automatic test_fence();
    int st, iw;
    logic [31:0] ld;
    op(1'b1, 32'h180, 32'h11, 3'd2, 1'b0, st, ld, iw);
    op(1'b0, '0, '0, '0, 1'b1, st, ld, iw);
    checks++; if (st !== 1) begin failures++; $display("FAIL fence_stalls got=%0d exp=1", st); end
    op(1'b0, '0, '0, '0, 1'b1, st, ld, iw);
    checks++; if (st !== 0) begin failures++; $display("FAIL fence_empty got=%0d exp=0", st); end
  endtask

  task automatic test_random();
    logic hold, v, w, ram, cov;
    logic [31:0] a, d;
    logic [2:0] f;
    int kind, n, es, la, raw, exp_stall, exp_drain;
    hold = 1'b0;
    v = 1'b0; w = 1'b0; a = '0; d = '0; f = '0;
    q.delete();
    for (int c = 0; c < 400; c++) begin
      if (!hold) begin
        kind = $urandom_range(0, 9);
        v = kind >= 2;
        w = kind < 5;
        d = $urandom;
        f = w ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 4));
        if (!w && f == 3'd3) f = 3'd5;
        a = 32'h100 + (32'($urandom_range(0, 15)) & ~32'(sz(f) - 1));
        if ($urandom_range(0, 9) == 0) a = w ? 32'h1000_0000 : 32'h1001_0000;
        if (!is_ram(a)) f = 3'd2;
      end
      drive(v, w, a, d, f, 1'b0);
      @(negedge i_clk);
      ram = is_ram(a);
      la = int'(a[15:0]);
      n = 0;
      cov = 1'b0;
      foreach (q[i]) begin
        es = int'({q[i].addr[15:2], 2'b00}) + store_lo(q[i].addr, q[i].f3);
        if (ram && is_ram(q[i].addr) && es < la + sz(f) && la < es + sz(q[i].f3)) begin
          n++;
          cov = es <= la && la + sz(f) <= es + sz(q[i].f3);
        end
      end
      raw = int'(v && !w && (ram ? n > 0 : q.size() > 0));
      exp_stall = int'(raw != 0 && !(FWD && ram && n == 1 && cov && (la % 4) + sz(f) <= 4));
      exp_drain = int'(q.size() > 0 && !(v && !w && raw == 0));
      checks++; if (o_sb_count !== q.size()) begin failures++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, o_sb_count, q.size()); end
      checks++; if (o_stall !== exp_stall[0]) begin failures++; $display("FAIL rnd_stall c=%0d got=%b exp=%0d", c, o_stall, exp_stall); end
      checks++; if (o_lsu_wren !== exp_drain[0]) begin failures++; $display("FAIL rnd_wren c=%0d got=%b exp=%0d", c, o_lsu_wren, exp_drain); end
      if (exp_drain != 0) begin
        checks++;
        if (o_lsu_addr !== q[0].addr || o_lsu_st_data !== q[0].data) begin
          failures++; $display("FAIL rnd_drain c=%0d got=%h/%h exp=%h/%h", c, o_lsu_addr, o_lsu_st_data, q[0].addr, q[0].data);
        end
      end
      if (v && !w && exp_stall == 0) begin
        checks++; if (o_ld_data !== ref_load(a, f)) begin failures++; $display("FAIL rnd_load c=%0d addr=%h got=%h exp=%h", c, a, o_ld_data, ref_load(a, f)); end
      end
      step();
      if (exp_drain != 0) void'(q.pop_front());
      if (v && w) begin
        q.push_back('{addr: a, data: d, f3: f});
        ref_store(a, d, f);
      end
      hold = exp_stall != 0;
    end
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
    step();
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_sw_lw();
    test_partial();
    test_forward();
    test_back_to_back();
    test_io();
    test_fence();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
